// File: rtl/disp_pkg.sv
// Shared defaults and helpers for the class-dispatch FIFO block.
package disp_pkg;

  localparam int unsigned DEF_DATA_SIZE = 10;
  localparam int unsigned DEF_MAIN_SIZE = 8;
  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_DEPTH     = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/disp_class_fifo_if.sv
// Word/pop request side and per-channel status side of the dispatcher.
interface disp_class_fifo_if #(
  parameter int unsigned DATA_SIZE = 10,
  parameter int unsigned MAIN_SIZE = 8,
  parameter int unsigned NUM_CH    = 4
);
  logic [DATA_SIZE-1:0]        in;
  logic                        valid;
  logic [NUM_CH-1:0]           pop;
  logic                        err_clr;
  logic [NUM_CH*MAIN_SIZE-1:0] out;
  logic [NUM_CH-1:0]           out_valid;
  logic [NUM_CH-1:0]           full;
  logic [NUM_CH-1:0]           almost_full;
  logic [NUM_CH-1:0]           err_full;
  logic [NUM_CH-1:0]           err_under;
  logic                        err_class;

  modport master (
    output in, valid, pop, err_clr,
    input  out, out_valid, full, almost_full, err_full, err_under, err_class
  );

  modport slave (
    input  in, valid, pop, err_clr,
    output out, out_valid, full, almost_full, err_full, err_under, err_class
  );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word and registered flags.
module fifo_fwft
  import disp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr, rptr_inc;
  logic [CNT_W-1:0] count_n;
  logic [WIDTH-1:0] head_n;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rptr_inc = rptr + PTR_W'(1);
    count_n  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_n   = dout;
    if (count_n == '0)
      head_n = '0;
    else if (do_pop)
      head_n = (count > CNT_W'(1)) ? mem[rptr_inc] : din;
    else if (empty && do_push)
      head_n = din;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      dout        <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (do_pop)  rptr <= rptr_inc;
      if (do_push) wptr <= wptr + PTR_W'(1);
      count       <= count_n;
      dout        <= head_n;
      empty       <= (count_n == '0);
      full        <= (count_n == CNT_W'(DEPTH));
      almost_full <= (count_n >= CNT_W'(DEPTH - 1));
    end
  end

endmodule

// File: rtl/disp_class_fifo.sv
// Routes each valid word to the FIFO selected by its class field; keeps sticky error flags.
module disp_class_fifo
  import disp_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned MAIN_SIZE = DEF_MAIN_SIZE,
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input logic              clk,
  input logic              reset,
  disp_class_fifo_if.slave bus
);

  localparam int unsigned CLASS_W = DATA_SIZE - MAIN_SIZE;
  localparam int unsigned CNT_W   = clog2(DEPTH) + 1;

  logic [CLASS_W-1:0]   cls;
  logic                 class_ok;
  logic [NUM_CH-1:0]    push_req, full_ev, under_ev;
  logic [MAIN_SIZE-1:0] dout_a  [NUM_CH];
  logic [CNT_W-1:0]     count_a [NUM_CH];
  logic                 empty_a [NUM_CH];
  logic                 full_a  [NUM_CH];
  logic                 afull_a [NUM_CH];
  logic [NUM_CH-1:0]    err_full_q, err_under_q;
  logic                 err_class_q;

  // Class decode plus the error events seen this cycle.
  always_comb begin
    cls      = bus.in[DATA_SIZE-1:MAIN_SIZE];
    class_ok = ({1'b0, cls} < (CLASS_W + 1)'(NUM_CH));
    push_req = '0;
    full_ev  = '0;
    under_ev = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      push_req[k] = bus.valid && class_ok && (cls == CLASS_W'(k));
      full_ev[k]  = push_req[k] && (count_a[k] == CNT_W'(DEPTH)) && !bus.pop[k];
      under_ev[k] = bus.pop[k] && empty_a[k];
    end
  end

  for (genvar k = 0; k < int'(NUM_CH); k++) begin : gen_ch
    fifo_fwft #(
      .WIDTH(MAIN_SIZE),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_req[k]),
      .pop        (bus.pop[k]),
      .din        (bus.in[MAIN_SIZE-1:0]),
      .dout       (dout_a[k]),
      .empty      (empty_a[k]),
      .full       (full_a[k]),
      .almost_full(afull_a[k]),
      .count      (count_a[k])
    );
  end

  // A new event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_full_q  <= '0;
      err_under_q <= '0;
      err_class_q <= 1'b0;
    end else begin
      err_full_q  <= (err_full_q  & {NUM_CH{!bus.err_clr}}) | full_ev;
      err_under_q <= (err_under_q & {NUM_CH{!bus.err_clr}}) | under_ev;
      err_class_q <= (err_class_q && !bus.err_clr) || (bus.valid && !class_ok);
    end
  end

  always_comb begin
    bus.out         = '0;
    bus.out_valid   = '0;
    bus.full        = '0;
    bus.almost_full = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      bus.out[k*MAIN_SIZE +: MAIN_SIZE] = dout_a[k];
      bus.out_valid[k]   = !empty_a[k];
      bus.full[k]        = full_a[k];
      bus.almost_full[k] = afull_a[k];
    end
    bus.err_full  = err_full_q;
    bus.err_under = err_under_q;
    bus.err_class = err_class_q;
  end

endmodule

// File: tb/tb_disp_class_fifo.sv
// Directed bench for disp_class_fifo: a 4-channel and a 3-channel instance.
module tb_disp_class_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  disp_class_fifo_if #(.DATA_SIZE(10), .MAIN_SIZE(8), .NUM_CH(4)) b4 ();
  disp_class_fifo_if #(.DATA_SIZE(10), .MAIN_SIZE(8), .NUM_CH(3)) b3 ();

  disp_class_fifo #(.DATA_SIZE(10), .MAIN_SIZE(8), .NUM_CH(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave)
  );
  disp_class_fifo #(.DATA_SIZE(10), .MAIN_SIZE(8), .NUM_CH(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [9:0] w);
    b4.in    = w;
    b4.valid = 1'b1;
    step();
    b4.valid = 1'b0;
  endtask

  task automatic pop4(input logic [3:0] p);
    b4.pop = p;
    step();
    b4.pop = '0;
  endtask

  initial begin
    b4.in = '0; b4.valid = 1'b0; b4.pop = '0; b4.err_clr = 1'b0;
    b3.in = '0; b3.valid = 1'b0; b3.pop = '0; b3.err_clr = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    check("rst_out_valid", 32'(b4.out_valid), 32'h0);
    check("rst_out", b4.out, 32'h0);
    check("rst_flags", {b4.full, b4.almost_full, b4.err_full, b4.err_under, 15'(b4.err_class)}, 32'h0);
    reset = 1'b0;
    step();

    // Three classes on consecutive cycles; FWFT visible right after the push edge
    b4.valid = 1'b1;
    b4.in = 10'h0FF; step();
    check("fwft_first", {24'(b4.out_valid), b4.out[7:0]}, {24'h1, 8'hFF});
    b4.in = 10'h2DD; step();
    b4.in = 10'h1BB; step();
    b4.valid = 1'b0;
    check("three_valid", 32'(b4.out_valid), 32'h7);
    check("three_data", b4.out, 32'h00DDBBFF);
    check("three_noerr", {b4.err_full, b4.err_under, 24'(b4.err_class)}, 32'h0);

    // Pop three channels in one cycle
    pop4(4'b0111);
    check("multi_pop_valid", 32'(b4.out_valid), 32'h0);
    check("multi_pop_out", b4.out, 32'h0);

    // Fill ch0, overflow once, drain in order
    push4(10'h0A0); push4(10'h0A1); push4(10'h0A2);
    check("af_at_3", {b4.almost_full, b4.full}, 32'h10);
    push4(10'h0A3);
    check("full_at_4", {b4.almost_full, b4.full, b4.err_full}, 32'h110);
    push4(10'h0A4);
    check("err_full_at_5", {b4.full, b4.err_full}, 32'h11);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), {24'(b4.out_valid[0]), b4.out[7:0]}, {24'h1, 8'(8'hA0 + i)});
      pop4(4'b0001);
    end
    check("drained", {b4.out_valid, b4.full, b4.almost_full}, 32'h0);
    b4.err_clr = 1'b1; step(); b4.err_clr = 1'b0;
    check("err_full_clr", 32'(b4.err_full), 32'h0);

    // Push and pop on a full channel in the same cycle
    push4(10'h0A0); push4(10'h0A1); push4(10'h0A2); push4(10'h0A3);
    b4.in = 10'h0A9; b4.valid = 1'b1; b4.pop = 4'b0001;
    step();
    b4.valid = 1'b0; b4.pop = '0;
    check("full_swap", {b4.full, b4.err_full, b4.err_under, 12'h0, b4.out[7:0]}, {4'h1, 4'h0, 4'h0, 12'h0, 8'hA1});
    check("swap_a2", 32'(b4.out[7:0]), 32'hA1);
    pop4(4'b0001);
    check("swap_a2b", 32'(b4.out[7:0]), 32'hA2);
    pop4(4'b0001);
    check("swap_a3", 32'(b4.out[7:0]), 32'hA3);
    pop4(4'b0001);
    check("swap_a9", 32'(b4.out[7:0]), 32'hA9);
    pop4(4'b0001);
    check("swap_empty", 32'(b4.out_valid), 32'h0);

    // Class 3 is legal with four channels
    push4(10'h3CC);
    check("class3_ok", {8'(b4.out_valid), 8'(b4.err_class), b4.out[31:24], 8'h0}, {8'h8, 8'h0, 8'hCC, 8'h0});
    pop4(4'b1000);

    // Underflow on ch1, push+pop on empty ch2
    pop4(4'b0010);
    check("under_ch1", {b4.err_under, b4.out_valid}, 32'h20);
    b4.in = 10'h2EE; b4.valid = 1'b1; b4.pop = 4'b0100;
    step();
    b4.valid = 1'b0; b4.pop = '0;
    check("push_pop_empty", {20'(b4.err_under), 4'(b4.out_valid), b4.out[23:16]}, {20'h6, 4'h4, 8'hEE});

    // Clear coinciding with a fresh ch1 underflow keeps ch1 set
    b4.err_clr = 1'b1; b4.pop = 4'b0010;
    step();
    b4.err_clr = 1'b0; b4.pop = '0;
    check("clr_vs_event", 32'(b4.err_under), 32'h2);

    // Reset mid-traffic clears everything without a clock edge
    push4(10'h111);
    push4(10'h3C0); push4(10'h3C1); push4(10'h3C2); push4(10'h3C3);
    check("pre_reset", {b4.out_valid, b4.full}, 32'hE8);
    reset = 1'b1;
    #1;
    check("async_rst_status", {b4.out_valid, b4.full, b4.almost_full, b4.err_full, b4.err_under}, 32'h0);
    check("async_rst_out", b4.out, 32'h0);
    step();
    reset = 1'b0;
    step();
    push4(10'h177);
    check("post_reset_first", {24'(b4.out_valid), b4.out[15:8]}, {24'h2, 8'h77});
    pop4(4'b0010);
    check("post_reset_drain", 32'(b4.out_valid), 32'h0);

    // Out-of-range class on the 3-channel instance
    b3.in = 10'h055; b3.valid = 1'b1; step();
    b3.in = 10'h3CC; step();
    b3.valid = 1'b0;
    check("bad_class_flag", 32'(b3.err_class), 32'h1);
    check("bad_class_fifos", {8'(b3.out_valid), b3.out}, {8'h1, 24'h000055});
    b3.err_clr = 1'b1; step(); b3.err_clr = 1'b0;
    check("bad_class_clr", 32'(b3.err_class), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_class_fifo.md
DISP_CLASS_FIFO -- requirements
Module: disp_class_fifo

Interface
REQ-001 Parameter DATA_SIZE, default 10, SHALL set the input word width: class field plus payload.
REQ-002 Parameter MAIN_SIZE, default 8, SHALL set the payload width; class field CLASS_W = DATA_SIZE-MAIN_SIZE.
REQ-003 Parameter NUM_CH, default 4, SHALL set the output channel count, with 2 <= NUM_CH <= 2**CLASS_W.
REQ-004 Parameter DEPTH, default 4, SHALL set the per-channel FIFO depth, a power of 2 and >= 2.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port in, input, DATA_SIZE: input word; class = in[DATA_SIZE-1:MAIN_SIZE], payload = in[MAIN_SIZE-1:0].
REQ-008 Port valid, input, 1: qualifies in for one cycle.
REQ-009 Port pop, input, NUM_CH: per-channel read strobe.
REQ-010 Port out, output, NUM_CH*MAIN_SIZE: channel k head payload at bits [k*MAIN_SIZE +: MAIN_SIZE].
REQ-011 Port out_valid, output, NUM_CH: channel k FIFO is non-empty.
REQ-012 Port full, output, NUM_CH: channel k holds DEPTH words.
REQ-013 Port almost_full, output, NUM_CH: channel k holds DEPTH-1 or more words.
REQ-014 Port err_full, output, NUM_CH: sticky flag; a push was dropped because channel k was full.
REQ-015 Port err_under, output, NUM_CH: sticky flag; pop was asserted while channel k was empty.
REQ-016 Port err_class, output, 1: sticky flag; a valid word carried class >= NUM_CH.
REQ-017 Port err_clr, input, 1: synchronous clear of all sticky error flags.

Function
REQ-018 A push to channel c SHALL occur when valid=1, c < NUM_CH, and the channel is not full or pop[c]=1 in the same cycle.
REQ-019 Each FIFO SHALL be first-word-fall-through: a word pushed at edge N SHALL appear on out with out_valid=1 after edge N.
REQ-020 pop[k] with out_valid[k]=1 SHALL remove the head at the edge; the next word or out_valid=0 SHALL be visible after that edge.
REQ-021 Push and pop on the same non-empty channel in one cycle SHALL leave occupancy unchanged, including when the channel is full.
REQ-022 Push and pop on an empty channel in one cycle SHALL accept the push, ignore the pop, and set err_under[k].
REQ-023 A push attempt to a full channel without a pop on that channel SHALL drop the word, set err_full[c], and leave the FIFO unchanged.
REQ-024 valid=1 with class >= NUM_CH SHALL drop the word and set err_class; no FIFO SHALL change.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be a log2(DEPTH)+1-bit counter.
REQ-026 Pops on different channels SHALL be independent, and all channels SHALL be serviceable in the same cycle.
REQ-027 Sticky errors SHALL hold until reset or err_clr=1.
REQ-028 If err_clr coincides with a new error event, the flag SHALL remain set.
REQ-029 valid=0 SHALL never change FIFO state, and the in value SHALL be ignored.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for a clock, clear all pointers and counters, out, out_valid, full, almost_full, err_full, err_under and err_class to 0.
REQ-031 Reset asserted mid-traffic SHALL discard all buffered words; the first push after release SHALL be the first word read.
REQ-032 Storage arrays need not be cleared; out SHALL read 0 while out_valid=0.

Structure
REQ-033 Shared package disp_pkg SHALL hold the default DATA_SIZE, MAIN_SIZE, NUM_CH and DEPTH constants and a clog2 function.
REQ-034 One sub-module, fifo_fwft (MAIN_SIZE wide, DEPTH deep, with push, pop, dout, empty, full, almost_full and count), SHALL be instantiated NUM_CH times by generate.
REQ-035 Class decode and error logic SHALL reside in disp_class_fifo.

Verification
REQ-036 Reset, then in=0x0FF, 0x2DD, 0x1BB on consecutive cycles with pop=0 -> out_valid=0111, ch0=FF, ch1=BB, ch2=DD, no errors.
REQ-037 Five pushes of 0x0A0..0x0A4 to ch0 with DEPTH=4 and no pop -> full[0]=1 after the 4th, err_full[0]=1 after the 5th, then pops read A0..A3.
REQ-038 ch0 full, and in=0x0A9 with pop[0]=1 in the same cycle -> A0 popped, A9 accepted, full[0] stays 1, no error.
REQ-039 NUM_CH=3 and in=0x3CC -> err_class=1 and all FIFOs unchanged; err_clr=1 -> err_class=0 next cycle.
REQ-040 pop[1]=1 on empty ch1 -> err_under[1]=1, out_valid[1]=0; reset asserted mid-stream -> all outputs 0 immediately.
